data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//   Data memory for the MEM stage of the 5-stage pipeline. Byte-addressed, word-wide (B bits) store.
//   Stores are synchronous on the rising clock edge. Loads are combinational, so the MEM/WB register
//   captures read data in the same cycle. Addressed by the low W bits of the ALU result.
// PARAMETERS
//   B  32  data/word width in bits; multiple of 8, >= 16
//   W  10  byte-address width; capacity = 2**W bytes = 2**W/(B/8) words (default 256 x 32)
// PORTS
//   i_clk        in   1   clock, rising-edge active
//   i_reset      in   1   asynchronous, active-high reset
//   i_mem_read   in   1   load enable
//   i_mem_write  in   1   store enable
//   i_addr       in   W   byte address, i.e. alu_result[W-1:0]
//   i_data       in   B   store data (rt value)
//   o_data       out  B   load data
// BEHAVIOUR
//   - Storage: array of NWORDS = 2**W/(B/8) words of B bits.
//     Word index = i_addr[W-1:OFS], where OFS = log2(B/8) (2 for B=32).
//   - Alignment: the low OFS address bits are ignored. Misaligned addresses act on the enclosing
//     aligned word; no fault is raised.
//   - Reset: while i_reset=1, asynchronously clear every word to 0; o_data = 0; stores are blocked.
//     Deassertion takes effect at the next rising edge. Reset mid-store cancels that store.
//   - Store: at posedge i_clk, with i_reset=0 and i_mem_write=1: mem[idx] <= i_data.
//     New data is visible on o_data immediately after that edge.
//   - Load: combinational. o_data = i_mem_read ? mem[idx] : 0. Zero latency; follows i_addr changes
//     within the same cycle.
//   - Simultaneous read+write, same word: before the edge o_data shows the old content;
//     after the edge it shows the new data. No bypass.
//   - i_mem_read=0 and i_mem_write=0: memory holds; o_data = 0.
//   - Addresses wrap naturally: only W bits exist, so the highest word (idx NWORDS-1) is valid.
//     No out-of-range condition.
//   - No handshake and no stall. Each access completes in one cycle.
// STRUCTURE
//   - Shared pipeline package holds: DATA_W (32) and DMEM_AW (10) defaults, and a helper function
//     computing OFS from B.
//   - Single module: one always block (async reset + sync write) plus a continuous-assign read mux.
//     No sub-module is needed.
//   - The array is implemented in registers because of the async clear; it is not inferred as BRAM.
// TESTING
//   Clock period 20 ns; change stimulus away from rising edges.
//   1. Reset: assert i_reset, i_mem_read=1, addr 0..0x3FC step 4 -> o_data=0 everywhere.
//   2. Stores: i_mem_write=1, addr=i*4, data=i for i=0..9; then i_mem_write=0.
//      Loads: i_mem_read=1, addr=i*4 -> o_data=i after at most one cycle
//      (combinational: same cycle).
//   3. Gating: i_mem_read=0 at addr 4 (holding 1) -> o_data=0. Raise i_mem_read -> 1 with no
//      clock edge.
//   4. Same-word read+write: addr 8 holds 2; write 0xDEADBEEF with read=1 -> o_data=2 before the
//      edge, 0xDEADBEEF after it.
//   5. Alignment/wrap: write 0x55 at addr 0x3FD -> readable at 0x3FC; addr 0x000 unaffected.
//   6. Mid-operation reset: pulse i_reset between edges during a store sequence -> all words read 0;
//      the cancelled store is absent.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared pipeline constants for the data-memory slice: default word/address widths
// and the byte-offset helper used to turn a byte address into a word index.
package data_mem_pkg;

  localparam int DATA_W  = 32;
  localparam int DMEM_AW = 10;

  // Number of low address bits that select a byte within one word.
  function automatic int ofsBits(input int wordBits);
    return $clog2(wordBits / 8);
  endfunction

endpackage

// File: rtl/data_mem.sv
// MEM-stage data memory: byte-addressed, word-wide register array with async clear,
// synchronous stores and a combinational, read-enable-gated load path.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int B = DATA_W,
  parameter int W = DMEM_AW
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [W-1:0] i_addr,
  input  logic [B-1:0] i_data,
  output logic [B-1:0] o_data
);

  localparam int OFS    = ofsBits(B);
  localparam int IDX_W  = W - OFS;
  localparam int NWORDS = 2 ** IDX_W;

  logic [B-1:0]     memQ [NWORDS];
  logic [IDX_W-1:0] wordIdx;
  logic             unusedAddrBits;

  // Misaligned addresses fold onto the enclosing word, so the byte offset is dropped.
  assign wordIdx        = i_addr[W-1:OFS];
  assign unusedAddrBits = ^i_addr[OFS-1:0];

  // Registers rather than RAM so that reset can clear every word at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NWORDS; k++) begin
        memQ[k] <= '0;
      end
    end else if (i_mem_write) begin
      memQ[wordIdx] <= i_data;
    end
  end

  assign o_data = (i_mem_read && !i_reset) ? memQ[wordIdx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset clear, store/load, read gating,
// same-word read+write ordering, alignment folding and a reset that cancels a store.
module tb_data_mem;

  logic        i_clk;
  logic        i_reset;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [9:0]  i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;

  int checkCount = 0;
  int passCount  = 0;

  data_mem #(.B(32), .W(10)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .o_data      (o_data)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one input set at the falling edge so nothing changes near a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [9:0] addr,
                               input logic [31:0] data);
    @(negedge i_clk);
    i_mem_read  = rd;
    i_mem_write = wr;
    i_addr      = addr;
    i_data      = data;
  endtask

  task automatic checkAllZero(input string phase);
    for (int a = 0; a < 1024; a += 4) begin
      i_addr = 10'(a);
      #1;
      checkOutput($sformatf("%s_addr%03h", phase, a), o_data, 32'h0);
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_mem_read  = 1'b1;
    i_mem_write = 1'b0;
    i_addr      = '0;
    i_data      = '0;

    // Reset holds every word at zero.
    @(negedge i_clk);
    checkAllZero("reset");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Stores 0..9, each visible right after its edge.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 10'(i * 4), 32'(i));
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("storeVis%0d", i), o_data, 32'(i));
    end
    applyStimulus(1'b1, 1'b0, 10'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      i_addr = 10'(i * 4);
      #1;
      checkOutput($sformatf("load%0d", i), o_data, 32'(i));
    end

    // Read gating without any clock edge.
    applyStimulus(1'b0, 1'b0, 10'h004, 32'h0);
    #1;
    checkOutput("gateOff", o_data, 32'h0);
    i_mem_read = 1'b1;
    #1;
    checkOutput("gateOn", o_data, 32'h1);

    // Same-word read+write: old data before the edge, new data after.
    applyStimulus(1'b1, 1'b1, 10'h008, 32'hDEADBEEF);
    #1;
    checkOutput("rwBefore", o_data, 32'h2);
    @(posedge i_clk);
    #1;
    checkOutput("rwAfter", o_data, 32'hDEADBEEF);

    // Misaligned store folds onto its aligned word.
    applyStimulus(1'b1, 1'b1, 10'h3FD, 32'h55);
    @(posedge i_clk);
    applyStimulus(1'b1, 1'b0, 10'h3FC, 32'h0);
    #1;
    checkOutput("alignFC", o_data, 32'h55);
    i_addr = 10'h3FF;
    #1;
    checkOutput("alignFF", o_data, 32'h55);
    i_addr = 10'h3F8;
    #1;
    checkOutput("alignF8", o_data, 32'h0);
    i_addr = 10'h000;
    #1;
    checkOutput("align000", o_data, 32'h0);
    i_addr = 10'h024;
    #1;
    checkOutput("neighbour24", o_data, 32'h9);

    // Reset pulse mid-store: the pending store at 0x10 must never land.
    applyStimulus(1'b1, 1'b1, 10'h010, 32'hA5A5A5A5);
    #5;
    i_reset = 1'b1;
    #1;
    checkOutput("rstOut", o_data, 32'h0);
    @(posedge i_clk);
    #3;
    i_reset = 1'b0;
    i_mem_write = 1'b0;
    #1;
    checkOutput("cancelled10", o_data, 32'h0);
    checkAllZero("midrst");

    // Stores work again after reset release.
    applyStimulus(1'b1, 1'b1, 10'h020, 32'h7);
    @(posedge i_clk);
    applyStimulus(1'b1, 1'b0, 10'h020, 32'h0);
    #1;
    checkOutput("postRst20", o_data, 32'h7);
    i_addr = 10'h01C;
    #1;
    checkOutput("postRst1C", o_data, 32'h0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
